riscv_fetch_unit: RTL and testbench

Parametrised, decoupled instruction-fetch front end for the pipelined core. It replaces the single-PC, zero-latency fetch with a request/response memory port, a bounded number of outstanding requests, and an instruction queue toward decode. Branch redirects from EXE flush the queue and discard in-flight responses. It sits between the instruction memory and the IF/ID register.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_queue.sv | 62 ++++++
 rtl/riscv_fetch_unit.sv | 107 ++++++++++
 tb/tb_riscv_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants for the RISC-V core front end.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue between the memory response port and decode.
// Flush takes priority over push and pop; storage is reset to zero.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // The parent's credit rule must make an overrun impossible.
  assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop && !flush));

endmodule

// File: rtl/riscv_fetch_unit.sv
// Decoupled instruction fetch: credit-limited request issue, in-order response
// capture into a queue, and redirect handling that discards stale responses.
module riscv_fetch_unit #(
  parameter int              XLEN            = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              FQ_DEPTH        = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [XLEN-1:0]           imem_req_addr,
  input  logic                      imem_rsp_valid,
  input  logic [31:0]               imem_rsp_data,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           redirect_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [31:0]               out_instr,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  import riscv_pkg::*;

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  rsp_pc;
  logic [XLEN-1:0]  redirect_pc_al;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] drop_cnt;
  logic             req_fire;
  logic             rsp_drop;
  logic             q_push;
  logic             q_pop;
  logic             q_empty;
  logic             q_full;
  fetch_entry_t     q_in;
  fetch_entry_t     q_head;

  assign redirect_pc_al = redirect_pc & ~XLEN'(3);

  // Only issue when the queue is guaranteed a slot for every outstanding response.
  assign imem_req_valid = rst && !redirect_valid
                       && (32'(inflight) < MAX_OUTSTANDING)
                       && ((32'(fq_count) + 32'(inflight)) < FQ_DEPTH);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = redirect_valid || (drop_cnt != '0);
  assign q_push   = imem_rsp_valid && !rsp_drop;
  assign q_in     = '{pc: rsp_pc, instr: imem_rsp_data};

  assign out_valid = !q_empty && !redirect_valid;
  assign q_pop     = out_valid && out_ready;
  assign out_pc    = q_head.pc;
  assign out_instr = q_head.instr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_pc_al;
        rsp_pc   <= redirect_pc_al;
        // A response arriving this cycle is already discarded; drop the rest.
        drop_cnt <= inflight - CNT_W'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (q_push) begin
          rsp_pc <= rsp_pc + XLEN'(4);
        end
        if (imem_rsp_valid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CNT_W'(1);
        end
      end
      if (req_fire && !imem_rsp_valid) begin
        inflight <= inflight + CNT_W'(1);
      end else if (!req_fire && imem_rsp_valid) begin
        inflight <= inflight - CNT_W'(1);
      end
    end
  end

  fetch_queue #(
    .DEPTH(FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_entry(q_in),
    .pop       (q_pop),
    .head      (q_head),
    .count     (fq_count),
    .empty     (q_empty),
    .full      (q_full)
  );

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench for riscv_fetch_unit: a latency-programmable memory model,
// directed stimulus pushing hand-computed expectations, and a pop/compare monitor.
module tb_riscv_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  fq_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  exp_t exp_q[$];
  req_t pend[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   edge_cnt = 0;
  int   lat     = 1;

  always #5 clk = ~clk;

  riscv_fetch_unit #(
    .XLEN(32), .RESET_PC(32'h0000_0000), .FQ_DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .fq_count      (fq_count)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  task automatic expect_out(logic [31:0] pc, logic [31:0] instr);
    exp_q.push_back('{pc, instr});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Memory: word at address a is 32'hA000_0000 + a; response after lat cycles.
  always @(negedge clk) begin
    if (rst && imem_req_valid && imem_req_ready)
      pend.push_back('{imem_req_addr, edge_cnt + lat});
  end

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      if (pend.size() > 0 && pend[0].due <= edge_cnt) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hA000_0000 + pend[0].addr;
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  // Monitor: every accepted head is compared with the next expected entry.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got pc %h, expected no output", out_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fq_count", 32'(fq_count), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);

    // Streaming, 1-cycle memory, decode always ready.
    next_cycle();
    rst = 1'b1; imem_req_ready = 1'b1; out_ready = 1'b1;
    expect_out(32'h0, 32'hA000_0000);
    expect_out(32'h4, 32'hA000_0004);
    expect_out(32'h8, 32'hA000_0008);
    expect_out(32'hC, 32'hA000_000C);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("t1_out_valid", 32'(out_valid), 32'((c >= 2) && (c <= 5)));
      if (c == 0) check("t1_first_addr", imem_req_addr, 32'h0);
      next_cycle();
      if (c == 3) imem_req_ready = 1'b0;
    end

    // Fill the queue with decode stalled; redirect_pc low bits are ignored.
    redirect_valid = 1'b1; redirect_pc = 32'h2; imem_req_ready = 1'b1; out_ready = 1'b0;
    expect_out(32'h0, 32'hA000_0000);
    expect_out(32'h4, 32'hA000_0004);
    expect_out(32'h8, 32'hA000_0008);
    expect_out(32'hC, 32'hA000_000C);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) check("t2_redirect_no_req", 32'(imem_req_valid), 32'd0);
      if (c >= 1 && c <= 4) begin
        check("t2_req_valid", 32'(imem_req_valid), 32'd1);
        check("t2_req_addr", imem_req_addr, 32'(4 * (c - 1)));
      end
      if (c >= 5) check("t2_credit_stop", 32'(imem_req_valid), 32'd0);
      if (c == 7) begin
        check("t2_fq_count", 32'(fq_count), 32'd4);
        check("t2_head_pc", out_pc, 32'h0);
        check("t2_head_instr", out_instr, 32'hA000_0000);
      end
      next_cycle();
      if (c == 0) redirect_valid = 1'b0;
    end

    // Drain, and hold the memory port not-ready for 5 cycles.
    out_ready = 1'b1; imem_req_ready = 1'b0;
    expect_out(32'h10, 32'hA000_0010);
    expect_out(32'h14, 32'hA000_0014);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) check("t3_full_no_req", 32'(imem_req_valid), 32'd0);
      if (c >= 1 && c <= 6) begin
        check("t3_stall_valid", 32'(imem_req_valid), 32'd1);
        check("t3_stall_addr", imem_req_addr, 32'h10);
      end
      if (c == 7) check("t3_next_addr", imem_req_addr, 32'h14);
      if (c == 11) check("t3_fq_empty", 32'(fq_count), 32'd0);
      next_cycle();
      if (c == 5) imem_req_ready = 1'b1;
      if (c == 7) imem_req_ready = 1'b0;
    end

    // Redirect with two requests in flight and two entries queued.
    lat = 3; imem_req_ready = 1'b1; out_ready = 1'b0;
    expect_out(32'h100, 32'hA000_0100);
    expect_out(32'h104, 32'hA000_0104);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) check("t4_addr0", imem_req_addr, 32'h18);
      if (c == 1) check("t4_addr1", imem_req_addr, 32'h1C);
      if (c == 2) check("t4_max_outstanding", 32'(imem_req_valid), 32'd0);
      if (c == 5) check("t4_head_before", out_pc, 32'h18);
      if (c == 6) begin
        check("t4_fq_before", 32'(fq_count), 32'd2);
        check("t4_redirect_no_out", 32'(out_valid), 32'd0);
        check("t4_redirect_no_req", 32'(imem_req_valid), 32'd0);
      end
      if (c == 7) begin
        check("t4_fq_flushed", 32'(fq_count), 32'd0);
        check("t4_out_after", 32'(out_valid), 32'd0);
      end
      if (c == 8) begin
        check("t4_restart_valid", 32'(imem_req_valid), 32'd1);
        check("t4_restart_addr", imem_req_addr, 32'h100);
      end
      if (c == 9) check("t4_addr_104", imem_req_addr, 32'h104);
      next_cycle();
      if (c == 5) begin redirect_valid = 1'b1; redirect_pc = 32'h100; end
      if (c == 6) begin redirect_valid = 1'b0; out_ready = 1'b1; end
      if (c == 9) imem_req_ready = 1'b0;
    end

    // Redirect coinciding with the only outstanding response.
    lat = 1; imem_req_ready = 1'b1;
    expect_out(32'h200, 32'hA000_0200);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) check("t5_addr", imem_req_addr, 32'h108);
      if (c == 1) check("t5_redirect_no_req", 32'(imem_req_valid), 32'd0);
      if (c == 2) begin
        check("t5_restart_addr", imem_req_addr, 32'h200);
        check("t5_restart_valid", 32'(imem_req_valid), 32'd1);
        check("t5_fq_empty", 32'(fq_count), 32'd0);
      end
      if (c == 3) check("t5_no_bypass", 32'(out_valid), 32'd0);
      if (c == 4) check("t5_out_valid", 32'(out_valid), 32'd1);
      next_cycle();
      if (c == 0) begin imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200; end
      if (c == 1) begin redirect_valid = 1'b0; imem_req_ready = 1'b1; end
      if (c == 2) imem_req_ready = 1'b0;
    end

    // Asynchronous reset mid-stream.
    lat = 2; out_ready = 1'b0; imem_req_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) check("t6_addr", imem_req_addr, 32'h204);
      if (c == 3) begin
        check("t6_fq_before", 32'(fq_count), 32'd1);
        check("t6_out_before", 32'(out_valid), 32'd1);
      end
      next_cycle();
    end
    #2;
    rst = 1'b0;
    pend.delete();
    imem_rsp_valid = 1'b0;
    #1;
    check("t6_async_out_valid", 32'(out_valid), 32'd0);
    check("t6_async_fq_count", 32'(fq_count), 32'd0);
    check("t6_async_req_valid", 32'(imem_req_valid), 32'd0);
    check("t6_async_out_pc", out_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; imem_req_ready = 1'b1; out_ready = 1'b1;
    expect_out(32'h0, 32'hA000_0000);
    @(negedge clk);
    check("t6_reset_pc_valid", 32'(imem_req_valid), 32'd1);
    check("t6_reset_pc_addr", imem_req_addr, 32'h0);
    next_cycle();
    imem_req_ready = 1'b0;
    repeat (6) next_cycle();

    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
